// File: rtl/wb_ram_arbiter_if.sv
// Bus bundle for wb_ram_arbiter: CPU Wishbone request, UART RX byte strobe,
// servant_ram Wishbone port and RX ring status.
interface wb_ram_arbiter_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Wishbone legs use classic cyc/ack: a request holds cyc until the cycle
    // in which ack is high. i_rx_valid is a one-cycle strobe with no back-pressure.
    logic [31:0]   i_cpu_adr;
    logic          i_cpu_cyc;
    logic          i_cpu_we;
    logic [3:0]    i_cpu_sel;
    logic [31:0]   i_cpu_dat;
    logic [31:0]   o_cpu_rdt;
    logic          o_cpu_ack;
    logic          i_rx_valid;
    logic [7:0]    i_rx_data;
    logic [31:0]   o_ram_adr;
    logic          o_ram_cyc;
    logic          o_ram_we;
    logic [3:0]    o_ram_sel;
    logic [31:0]   o_ram_dat;
    logic [31:0]   i_ram_rdt;
    logic          i_ram_ack;
    logic [31:0]   o_wr_ptr;
    logic [CW-1:0] o_fifo_count;
    logic          o_ovf;
    logic          i_ovf_clr;
    logic [1:0]    o_dbg_state;

    modport slave (
        input  i_cpu_adr, i_cpu_cyc, i_cpu_we, i_cpu_sel, i_cpu_dat,
        input  i_rx_valid, i_rx_data, i_ram_rdt, i_ram_ack, i_ovf_clr,
        output o_cpu_rdt, o_cpu_ack, o_ram_adr, o_ram_cyc, o_ram_we,
        output o_ram_sel, o_ram_dat, o_wr_ptr, o_fifo_count, o_ovf, o_dbg_state
    );

    modport master (
        output i_cpu_adr, i_cpu_cyc, i_cpu_we, i_cpu_sel, i_cpu_dat,
        output i_rx_valid, i_rx_data, i_ram_rdt, i_ram_ack, i_ovf_clr,
        input  o_cpu_rdt, o_cpu_ack, o_ram_adr, o_ram_cyc, o_ram_we,
        input  o_ram_sel, o_ram_dat, o_wr_ptr, o_fifo_count, o_ovf, o_dbg_state
    );
endinterface

// File: rtl/wb_ram_arbiter.sv
// Shares the servant_ram Wishbone port between the CPU and a buffered UART RX
// byte stream that is written as zero-extended words into a circular RAM window.
module wb_ram_arbiter #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] ADR_LL     = 32'h300,
    parameter logic [31:0] ADR_UL     = 32'h1FFC,
    parameter int          MAX_WAIT   = 16
) (
    input logic              i_wb_clk,
    input logic              i_wb_rst_n,
    wb_ram_arbiter_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CPU  = 2'd1,
        S_RX   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  fifo_q [FIFO_DEPTH];
    logic [AW-1:0] rd_idx_q, rd_idx_d, wr_idx_q, wr_idx_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0] wr_ptr_q, wr_ptr_d;
    logic        ovf_q, ovf_d;
    logic [WW-1:0] wait_q, wait_d;

    logic        fifo_empty, fifo_full, pop, push_ok;
    logic [32:0] ptr_inc;

    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CW'(FIFO_DEPTH));
        pop        = (state_q == S_RX) && bus.i_ram_ack;
        // A full FIFO still accepts a byte when the head leaves in the same cycle.
        push_ok    = bus.i_rx_valid && (!fifo_full || pop);

        rd_idx_d = pop     ? rd_idx_q + AW'(1) : rd_idx_q;
        wr_idx_d = push_ok ? wr_idx_q + AW'(1) : wr_idx_q;
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        ptr_inc  = {1'b0, wr_ptr_q} + 33'd4;
        wr_ptr_d = wr_ptr_q;
        if (pop) wr_ptr_d = (ptr_inc > {1'b0, ADR_UL}) ? ADR_LL : ptr_inc[31:0];

        ovf_d = ovf_q;
        if (bus.i_ovf_clr) ovf_d = 1'b0;
        if (bus.i_rx_valid && fifo_full && !pop) ovf_d = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty && (fifo_full || wait_q >= WW'(MAX_WAIT) || !bus.i_cpu_cyc))
                    state_d = S_RX;
                else if (bus.i_cpu_cyc)
                    state_d = S_CPU;
            end
            S_CPU, S_RX: begin
                if (bus.i_ram_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Count how long buffered RX data has been passed over for the CPU.
        if (fifo_empty || (state_q == S_IDLE && state_d == S_RX))
            wait_d = '0;
        else if (state_q == S_IDLE && state_d == S_CPU && wait_q < WW'(MAX_WAIT))
            wait_d = wait_q + WW'(1);
    end

    always_comb begin
        bus.o_ram_cyc    = 1'b0;
        bus.o_ram_adr    = '0;
        bus.o_ram_we     = 1'b0;
        bus.o_ram_sel    = '0;
        bus.o_ram_dat    = '0;
        bus.o_cpu_ack    = 1'b0;
        bus.o_cpu_rdt    = bus.i_ram_rdt;
        bus.o_wr_ptr     = wr_ptr_q;
        bus.o_fifo_count = count_q;
        bus.o_ovf        = ovf_q;
        bus.o_dbg_state  = state_q;
        // cyc comes from the registered grant only, never from i_cpu_cyc.
        unique case (state_q)
            S_CPU: begin
                bus.o_ram_cyc = 1'b1;
                bus.o_ram_adr = bus.i_cpu_adr;
                bus.o_ram_we  = bus.i_cpu_we;
                bus.o_ram_sel = bus.i_cpu_sel;
                bus.o_ram_dat = bus.i_cpu_dat;
                bus.o_cpu_ack = bus.i_ram_ack;
            end
            S_RX: begin
                bus.o_ram_cyc = 1'b1;
                bus.o_ram_adr = wr_ptr_q;
                bus.o_ram_we  = 1'b1;
                bus.o_ram_sel = 4'b1111;
                bus.o_ram_dat = {24'b0, fifo_q[rd_idx_q]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_wb_clk) begin
        if (push_ok) fifo_q[wr_idx_q] <= bus.i_rx_data;
    end

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            state_q  <= S_IDLE;
            rd_idx_q <= '0;
            wr_idx_q <= '0;
            count_q  <= '0;
            wr_ptr_q <= ADR_LL;
            ovf_q    <= 1'b0;
            wait_q   <= '0;
        end else begin
            state_q  <= state_d;
            rd_idx_q <= rd_idx_d;
            wr_idx_q <= wr_idx_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            ovf_q    <= ovf_d;
            wait_q   <= wait_d;
        end
    end
endmodule
